// File: rtl/scan_mux_if.sv
// Bus bundle for scan_mux: run controls and channel data in, registered
// selected channel out.
interface scan_mux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4
);
  localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic                      en;
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic [CHANNELS*WIDTH-1:0] d;
  logic [WIDTH-1:0]          q;
  logic [SELW-1:0]           q_sel;
  logic                      q_valid;
  logic                      wrap;

  modport master (output en, mode, sel, d, input q, q_sel, q_valid, wrap);
  modport slave  (input en, mode, sel, d, output q, q_sel, q_valid, wrap);
endinterface

// File: rtl/scan_mux.sv
// Channel scan multiplexer: manual select or auto scan with a per-channel
// dwell, forced blanking on every channel change, all outputs registered.
module scan_mux #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 4,
  parameter int PRESCALE  = 50,
  parameter int BLANK_CYC = 1
) (
  input  logic      clk,
  input  logic      rst,
  scan_mux_if.slave bus
);
  localparam int SELW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam logic [SELW-1:0] CLAST = SELW'(CHANNELS - 1);
  localparam logic [15:0]     PLAST = 16'(PRESCALE - 1);
  localparam logic [7:0]      BLAST = 8'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} st_t;
  // With no blank cycles configured, a channel change lands directly in SHOW.
  localparam st_t ENTER = (BLANK_CYC == 0) ? SHOW : BLANK;

  st_t                          state, state_n;
  logic [SELW-1:0]              ch, ch_n, csel;
  logic [15:0]                  pc, pc_n;
  logic [7:0]                   bc, bc_n;
  logic                         wrap_n, mode_r, mode_chg;
  logic [CHANNELS-1:0][WIDTH-1:0] dv;

  assign dv       = bus.d;
  assign csel     = (32'(bus.sel) >= CHANNELS) ? CLAST : bus.sel;
  assign mode_chg = (bus.mode != mode_r);

  always_comb begin
    state_n = state;
    ch_n    = ch;
    pc_n    = pc;
    bc_n    = bc;
    wrap_n  = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
      pc_n    = '0;
      bc_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          ch_n    = bus.mode ? '0 : csel;
          pc_n    = '0;
          bc_n    = '0;
          state_n = ENTER;
        end
        default: begin
          if (mode_chg) begin
            pc_n    = '0;
            bc_n    = '0;
            ch_n    = bus.mode ? ch : csel;
            state_n = ENTER;
          end else if (state == BLANK) begin
            if (bc == BLAST) begin
              bc_n    = '0;
              state_n = SHOW;
            end else begin
              bc_n = bc + 8'd1;
            end
          end else if (bus.mode) begin
            if (pc == PLAST) begin
              pc_n    = '0;
              ch_n    = (ch == CLAST) ? '0 : ch + 1'b1;
              wrap_n  = (ch == CLAST);
              state_n = ENTER;
            end else begin
              pc_n = pc + 16'd1;
            end
          end else if (csel != ch) begin
            ch_n    = csel;
            state_n = ENTER;
          end
        end
      endcase
    end
  end

  // Outputs are registered from the next state so q_valid tracks SHOW exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= '0;
      pc          <= '0;
      bc          <= '0;
      mode_r      <= 1'b0;
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
      bus.wrap    <= 1'b0;
    end else begin
      state       <= state_n;
      ch          <= ch_n;
      pc          <= pc_n;
      bc          <= bc_n;
      mode_r      <= bus.mode;
      bus.wrap    <= wrap_n;
      bus.q_valid <= (state_n == SHOW);
      bus.q       <= (state_n == SHOW) ? dv[ch_n] : '0;
    end
  end

  assign bus.q_sel = ch;
endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: auto scan, manual select, clamp, enable drop,
// mode switch and asynchronous reset.
module tb_scan_mux;
  logic clk, rst;
  int   errors = 0;
  int   checks = 0;

  scan_mux_if #(.CHANNELS(4), .WIDTH(4)) bus4 ();
  scan_mux_if #(.CHANNELS(3), .WIDTH(4)) bus3 ();

  scan_mux #(.CHANNELS(4), .WIDTH(4), .PRESCALE(3), .BLANK_CYC(1)) u4 (
    .clk(clk), .rst(rst), .bus(bus4));
  scan_mux #(.CHANNELS(3), .WIDTH(4), .PRESCALE(3), .BLANK_CYC(1)) u3 (
    .clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int q, input int qv, input int qs, input int w);
    chk({tag, ".q"},       32'(bus4.q),       32'(q));
    chk({tag, ".q_valid"}, 32'(bus4.q_valid), 32'(qv));
    chk({tag, ".q_sel"},   32'(bus4.q_sel),   32'(qs));
    chk({tag, ".wrap"},    32'(bus4.wrap),    32'(w));
  endtask

  int exp_q [18] = '{0, 5, 5, 5, 0, 10, 10, 10, 0, 3, 3, 3, 0, 13, 13, 13, 0, 5};

  initial begin
    rst = 1'b1;
    bus4.en = 1'b0; bus4.mode = 1'b0; bus4.sel = '0; bus4.d = '0;
    bus3.en = 1'b0; bus3.mode = 1'b0; bus3.sel = '0; bus3.d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk4("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // auto scan through all four channels and the wrap
    bus4.d = 16'hD3A5; bus4.mode = 1'b1; bus4.en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      chk4($sformatf("auto[%0d]", i), exp_q[i], (i % 4 != 0) ? 1 : 0,
           (i / 4) % 4, (i == 16) ? 1 : 0);
    end

    // enable drop during SHOW of channel 1
    repeat (4) tick();
    chk4("pre_drop", 10, 1, 1, 0);
    bus4.en = 1'b0;
    tick();
    chk4("drop", 0, 0, 1, 0);
    tick();
    chk4("idle", 0, 0, 1, 0);
    bus4.en = 1'b1;
    tick();
    chk4("rerise_blank", 0, 0, 0, 0);
    tick();
    chk4("rerise_show", 5, 1, 0, 0);

    // mode switch at ch=2, pc=1
    repeat (9) tick();
    chk4("pre_switch", 3, 1, 2, 0);
    bus4.mode = 1'b0; bus4.sel = 2'd3;
    tick();
    chk4("switch_blank", 0, 0, 3, 0);
    tick();
    chk4("switch_show", 13, 1, 3, 0);
    tick();
    chk4("switch_hold", 13, 1, 3, 0);

    // manual select
    bus4.d = 16'h4321; bus4.sel = 2'd2;
    tick();
    chk4("man_blank", 0, 0, 2, 0);
    tick();
    chk4("man_show", 3, 1, 2, 0);
    tick();
    chk4("man_steady", 3, 1, 2, 0);
    bus4.sel = 2'd0;
    tick();
    chk4("man_chg_blank", 0, 0, 0, 0);
    tick();
    chk4("man_chg_show", 1, 1, 0, 0);
    bus4.d = 16'h4325;
    tick();
    chk4("man_latency", 5, 1, 0, 0);

    // back to auto, then async reset mid-scan
    bus4.mode = 1'b1;
    tick();
    chk4("to_auto_blank", 0, 0, 0, 0);
    tick();
    chk4("to_auto_show", 5, 1, 0, 0);
    repeat (3) tick();
    tick();
    chk4("pre_rst", 2, 1, 1, 0);
    #3 rst = 1'b1;
    #1;
    chk4("async_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    tick();
    chk4("post_rst_blank", 0, 0, 0, 0);
    tick();
    chk4("post_rst_show", 5, 1, 0, 0);

    // clamp on the three-channel instance
    bus3.d = 12'h7B9; bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.en = 1'b1;
    tick();
    chk("clamp_blank.q_sel", 32'(bus3.q_sel), 32'd2);
    chk("clamp_blank.q_valid", 32'(bus3.q_valid), 32'd0);
    tick();
    chk("clamp.q", 32'(bus3.q), 32'h7);
    chk("clamp.q_sel", 32'(bus3.q_sel), 32'd2);
    chk("clamp.q_valid", 32'(bus3.q_valid), 32'd1);
    bus3.sel = 2'd1;
    tick();
    chk("c3_chg_blank.q", 32'(bus3.q), 32'h0);
    tick();
    chk("c3_chg.q", 32'(bus3.q), 32'hB);
    chk("c3_chg.q_sel", 32'(bus3.q_sel), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of input channels, range 2..16.
REQ-002 SHALL have parameter WIDTH, default 4: bits per channel.
REQ-003 SHALL have parameter PRESCALE, default 50: SHOW-dwell cycles per channel in auto mode, range 1..65535.
REQ-004 SHALL have parameter BLANK_CYC, default 1: forced-blank cycles on every channel change, range 0..255.
REQ-005 SHALL use SELW = max(1, clog2(CHANNELS)) for the width of all select ports.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port en, input, 1 bit: run enable.
REQ-009 SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto scan.
REQ-010 SHALL have port sel, input, SELW bits: channel select used in manual mode.
REQ-011 SHALL have port d, input, CHANNELS*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port q, output, WIDTH bits: registered selected channel data.
REQ-013 SHALL have port q_sel, output, SELW bits: the current channel index ch.
REQ-014 SHALL have port q_valid, output, 1 bit: high only in SHOW.
REQ-015 SHALL have port wrap, output, 1 bit: one-cycle pulse on the auto-scan wrap from CHANNELS-1 to 0.

Function
REQ-016 SHALL implement three states, IDLE, BLANK and SHOW, where:
- BLANK counts BLANK_CYC cycles.
- SHOW has a prescale counter pc.
REQ-017 SHALL clamp manual select as csel = (sel >= CHANNELS) ? CHANNELS-1 : sel.
REQ-018 In IDLE, SHALL hold q = 0 and q_valid = 0; when en = 1, SHALL load ch = (mode ? 0 : csel) and enter BLANK.
REQ-019 In BLANK, SHALL drive q = 0 and q_valid = 0 for exactly BLANK_CYC cycles, then enter SHOW.
- If BLANK_CYC = 0, the transition that would enter BLANK SHALL enter SHOW directly.
REQ-020 In SHOW, SHALL set q <= d[ch*WIDTH +: WIDTH] every cycle, a one-cycle latency from d to q, and SHALL hold q_valid = 1.
REQ-021 In auto mode in SHOW, SHALL increment pc from 0 each cycle; when pc = PRESCALE-1, SHALL clear pc, set ch <= (ch = CHANNELS-1) ? 0 : ch+1, and enter BLANK.
REQ-022 SHALL assert wrap for exactly the cycle following the REQ-021 advance from CHANNELS-1 to 0.
REQ-023 In manual mode in SHOW, if csel != ch, SHALL set ch <= csel and enter BLANK; otherwise SHALL stay in SHOW.
REQ-024 SHALL act on a mode change (mode differs from its value registered on the previous cycle) seen in BLANK or SHOW by:
- clearing pc and the blank counter;
- setting ch <= (new mode manual ? csel : ch);
- entering BLANK.
REQ-025 SHALL, on en = 0 in any state, enter IDLE on the next edge and clear q, q_valid, wrap, pc and the blank counter.
- ch SHALL be retained.
- en = 0 SHALL take priority over every simultaneous event.
REQ-026 SHALL give an auto-mode mode-change (REQ-024) priority over a simultaneous pc terminal count (REQ-021).
REQ-027 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-028 While rst = 1, SHALL immediately force state = IDLE, q = 0, q_sel = 0, q_valid = 0, wrap = 0, pc = 0 and blank counter = 0, and SHALL clear the registered mode to 0.
REQ-029 After rst deasserts, SHALL leave IDLE no earlier than the first rising edge with en = 1.
REQ-030 If rst asserts mid-scan, SHALL discard all scan progress; the first post-reset auto scan SHALL start at channel 0.

Verification
(Bench parameters: CHANNELS=4, WIDTH=4, PRESCALE=3, BLANK_CYC=1.)
REQ-031 Auto scan: d = 16'hD3A5, mode = 1, en rises.
- Required q sequence after IDLE: 0 (blank), 5, 5, 5, 0, A, A, A, 0, 3, 3, 3, 0, D, D, D, 0, 5, ...
- wrap SHALL pulse once, during the blank that follows the last D.
REQ-032 Manual select: mode = 0, sel = 2, d = 16'h4321, steady state q = 3; sel changes to 0.
- Next cycle: q = 0, q_valid = 0.
- Following cycle: q = 1, q_sel = 0.
REQ-033 Clamp: CHANNELS=3 instance, manual mode, sel = 3 -> q_sel = 2, q = channel 2 data.
REQ-034 Enable drop: en falls during SHOW of channel 1 -> next cycle q = 0, q_valid = 0, q_sel = 1; en re-rises in auto mode -> blank, then channel 0 shown.
REQ-035 Mode switch: auto SHOW at ch = 2 with pc = 1, mode -> 0 with sel = 3 -> BLANK one cycle, then SHOW ch = 3, no wrap pulse.
REQ-036 Async reset: rst pulses between clock edges during SHOW -> outputs are 0 before the next edge; with en held at 1 after release, the scan restarts at channel 0 after one blank cycle.
